mem_access_unit: RTL
====================

# mem_access_unit

Load/store access unit for the multicycle RISC-V core. It sits directly downstream of the control unit's MEMORY state and sits between the datapath and word-organised data memory. On a one-cycle `start` it converts the byte address, `funct3` and store data into a word-aligned request with byte enables. It then holds the request until memory acknowledges, and returns a sign- or zero-extended load result with a one-cycle `done` pulse that the control unit waits on before write-back.

## Interface
Parameters:
- `WAIT_MAX`, default 255: maximum number of cycles the unit waits for `mem_ready`. Counter width is `$clog2(WAIT_MAX+1)`.

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `start`  in  1  request pulse from control. Sampled only in IDLE.
- `we`  in  1  1 = store, 0 = load.
- `funct3`  in  3  access size and signedness, RV32I encoding.
- `addr`  in  32  byte address (ALU result).
- `wdata`  in  32  store data (rs2).
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle completion pulse.
- `rdata`  out  32  extended load data. Held until the next load completes.
- `err`  out  1  one-cycle pulse coincident with `done` on a timeout, or on a misalign when the Configuration feature is compiled in.
- `mem_req`  out  1  memory request, held until accepted.
- `mem_we`  out  1  memory write strobe. Only meaningful when `mem_req` is high.
- `mem_addr`  out  32  `{addr[31:2], 2'b00}`.
- `mem_be`  out  4  byte lane enables.
- `mem_wdata`  out  32  lane-replicated store data.
- `mem_ready`  in  1  memory accept/complete. Read data is valid in the same cycle.
- `mem_rdata`  in  32  memory read word.

## Operation
- Reset values: state IDLE; wait counter 0; `busy`, `done` and `err` are 0; `rdata` is 0; all `mem_*` outputs are 0.
- FSM states and transitions:
  - IDLE → REQ on `start`. At that edge the unit latches `we`, `funct3`, `addr` and `wdata`.
  - REQ: `mem_req` is 1. The wait counter increments each cycle in which `mem_ready` is 0.
    - REQ → DONE on `mem_ready`=1.
    - REQ → DONE with `err`=1 when the counter reaches `WAIT_MAX`.
  - DONE: `done` is 1 for one cycle, then the FSM returns to IDLE.
- Byte enables and store data:
  - SB (`funct3[1:0]`=00): `mem_be = 4'b0001 << addr[1:0]`; the byte is replicated into all four lanes.
  - SH (01): `mem_be = addr[1] ? 4'b1100 : 4'b0011`; the halfword is replicated into both halves.
  - SW (10 or 11): `mem_be = 4'b1111`.
  - Loads use the same size decoding for `mem_be`; `mem_we` is 0.
- Load extraction, captured into `rdata` on the accepting edge:
  - LB (000) sign-extends the byte selected by `addr[1:0]`.
  - LBU (100) zero-extends the byte selected by `addr[1:0]`.
  - LH (001) sign-extends the halfword selected by `addr[1]`.
  - LHU (101) zero-extends the halfword selected by `addr[1]`.
  - LW (010) passes the word through.
  - Undefined codes 011, 110 and 111 are treated as LW.
- Stores never modify `rdata`. A timed-out load leaves `rdata` unchanged.
- A `start` pulse while `busy` is ignored and is not queued.
- Inputs are latched at start, so they may change freely while `busy`.

## Timing
- `start` sampled at edge k: `mem_req` is high from cycle k+1.
- `mem_ready` sampled high at edge k+1+n: `done` and `rdata` are valid during the following cycle, and `mem_req` is low in that cycle.
- Minimum latency from start to done is 2 cycles. `busy` stays high through the DONE cycle.
- A new `start` is accepted in the cycle immediately after DONE.
- `mem_addr`, `mem_be`, `mem_wdata` and `mem_we` are registered and stable for the whole REQ phase.
- Reset while in REQ: the FSM goes to IDLE at the reset edge, `mem_req` is 0 from the next cycle, and no `done` pulse is produced.
- `mem_ready` seen outside REQ is ignored.

## Configuration
- `MISALIGN_TRAP_EN` defined:
  - A halfword access with `addr[0]`=1, or a word access with `addr[1:0]`≠0, issues no memory request.
  - The FSM goes IDLE → DONE, and `err`=1 alongside `done`.
  - `rdata` and memory contents are unchanged.
- `MISALIGN_TRAP_EN` undefined:
  - Unused low address bits are ignored per size (halfword uses `addr[1]`; word ignores `addr[1:0]`).
  - The access proceeds normally. Misalignment never raises `err`.

## Test plan
- LB at addr 0x103 with `mem_rdata`=0x80FF_1234 and `mem_ready` high immediately → `mem_be`=1000, `rdata`=0xFFFF_FF80, `done` exactly 2 cycles after start.
- SH at addr 0x202, `wdata`=0xDEAD_BEEF → `mem_addr`=0x200, `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF, `mem_we`=1, `rdata` unchanged.
- LHU at addr 0x0 with `mem_ready` delayed 5 cycles, `mem_rdata`=0x0000_9ABC → `mem_req` held for 6 cycles, `rdata`=0x0000_9ABC, second `start` during the wait ignored.
- `mem_ready` never asserted, `WAIT_MAX`=4 → `err` and `done` pulse together, return to IDLE, `rdata` unchanged.
- `rst_n` low mid-REQ → `mem_req`=0 and `busy`=0 from the next cycle, no `done` pulse; a new LW then completes with `rdata` equal to `mem_rdata`.
- LW at addr 0x101: with `MISALIGN_TRAP_EN` → no `mem_req`, `err`=1 with `done`; without it → `mem_addr`=0x100, full word returned.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//
// Load/store access unit between the multicycle core datapath and a
// word-organised data memory. A one-cycle start pulse in IDLE latches the
// access, converts it into a word-aligned request with byte-lane enables and
// lane-replicated store data, holds the request until the memory accepts it
// (or a wait limit expires), then pulses done for one cycle. Loads return the
// selected byte/halfword/word, sign- or zero-extended, on rdata.
//
// Build option: define MISALIGN_TRAP_EN to trap misaligned halfword/word
// accesses (no memory request, err with done). Without it the unused low
// address bits are ignored and misalignment never raises err.
//
// Parameters:
//   WAIT_MAX   maximum number of cycles to wait for mem_ready
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   start, we, funct3     request pulse, store/load select, RV32I size code
//   addr, wdata           byte address, store data
//   busy, done, err       status: not idle, completion pulse, error pulse
//   rdata                 extended load result, held until next load completes
//   mem_req, mem_we       memory request and write strobe
//   mem_addr, mem_be      word address and byte-lane enables
//   mem_wdata             lane-replicated store data
//   mem_ready, mem_rdata  memory accept and read word (same cycle)

module mem_access_unit #(
  parameter int WAIT_MAX = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] rdata,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);
  // Last count value before the limit: a miss at this count ends the wait.
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             err_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             acc_we;
  logic [2:0]       acc_funct3;
  logic [1:0]       acc_off;

  function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                              input logic [1:0] off);
    case (size)
      2'b00:   lane_enables = 4'b0001 << off;
      2'b01:   lane_enables = off[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_data(input logic [1:0]  size,
                                            input logic [31:0] data);
    case (size)
      2'b00:   lane_data = {4{data[7:0]}};
      2'b01:   lane_data = {2{data[15:0]}};
      default: lane_data = data;
    endcase
  endfunction

  // Undefined size codes fall through to the full word.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [1:0]  off,
                                              input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  load_extend = {{24{b[7]}}, b};
      3'b100:  load_extend = {24'b0, b};
      3'b001:  load_extend = {{16{h[15]}}, h};
      3'b101:  load_extend = {16'b0, h};
      default: load_extend = word;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                      (funct3[1] && (addr[1:0] != 2'b00));
`endif

  assign busy    = (state != IDLE);
  assign done    = (state == DONE);
  assign mem_req = (state == REQ);
  assign mem_we  = acc_we;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    err_next   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MISALIGN_TRAP_EN
          if (misaligned) begin
            state_next = DONE;
            err_next   = 1'b1;
          end else begin
            state_next = REQ;
          end
`else
          state_next = REQ;
`endif
        end
      end
      REQ: begin
        // An accept in the final allowed cycle wins over the timeout.
        if (mem_ready) begin
          state_next = DONE;
        end else if (wait_cnt == WAIT_LAST) begin
          state_next = DONE;
          err_next   = 1'b1;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err        <= 1'b0;
      wait_cnt   <= '0;
      acc_we     <= 1'b0;
      acc_funct3 <= 3'b0;
      acc_off    <= 2'b0;
      mem_addr   <= 32'b0;
      mem_be     <= 4'b0;
      mem_wdata  <= 32'b0;
      rdata      <= 32'b0;
    end else begin
      err <= err_next;
      // Latch the whole access so the datapath may move on while busy.
      if ((state == IDLE) && start) begin
        acc_we     <= we;
        acc_funct3 <= funct3;
        acc_off    <= addr[1:0];
        mem_addr   <= {addr[31:2], 2'b00};
        mem_be     <= lane_enables(funct3[1:0], addr[1:0]);
        mem_wdata  <= lane_data(funct3[1:0], wdata);
        wait_cnt   <= '0;
      end
      if ((state == REQ) && !mem_ready) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      // Only an accepted load updates rdata; stores and timeouts leave it.
      if ((state == REQ) && mem_ready && !acc_we) begin
        rdata <= load_extend(acc_funct3, acc_off, mem_rdata);
      end
    end
  end

endmodule
